// File: rtl/id_decode_pipe.sv
// id_decode_pipe: ID stage for a MIPS32 integer subset.
// Decodes the instruction in ID and resolves branches and jumps there. It forwards operands
// from FWD_PORTS later stages and raises a load-use stall request. It owns the ID/EX
// pipeline register and the branch-delay-slot flag.
// Optional feature macro: ID_INVALID_TRAP_EN adds the registered ex_exc_ri_o output.
// aluop encoding: SPECIAL ops use {2'b00, funct}; all other known ops use {2'b01, opcode}.
// alusel encoding: 0 none, 1 arithmetic, 2 logic, 3 jump/branch, 4 load/store.
// SW carries the store data (rt) in reg2; EX takes the offset from ex_inst_o.
module id_decode_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_PORTS = 2,
  parameter int ALUOP_W   = 8,
  parameter int ALUSEL_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic [31:0]                 pc_i,
  input  logic [31:0]                 inst_i,
  input  logic                        inst_valid_i,
  output logic                        reg1_read_o,
  output logic [REG_AW-1:0]           reg1_addr_o,
  input  logic [DATA_W-1:0]           reg1_data_i,
  output logic                        reg2_read_o,
  output logic [REG_AW-1:0]           reg2_addr_o,
  input  logic [DATA_W-1:0]           reg2_data_i,
  input  logic [FWD_PORTS-1:0]        fwd_wreg_i,
  input  logic [FWD_PORTS*REG_AW-1:0] fwd_wd_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_wdata_i,
  input  logic                        ex_is_load_i,
  input  logic [REG_AW-1:0]           ex_wd_i,
  output logic                        stallreq_o,
  output logic                        branch_flag_o,
  output logic [31:0]                 branch_target_o,
  output logic [ALUOP_W-1:0]          ex_aluop_o,
  output logic [ALUSEL_W-1:0]         ex_alusel_o,
  output logic [DATA_W-1:0]           ex_reg1_o,
  output logic [DATA_W-1:0]           ex_reg2_o,
  output logic [REG_AW-1:0]           ex_wd_o,
  output logic                        ex_wreg_o,
  output logic [31:0]                 ex_link_addr_o,
  output logic [31:0]                 ex_inst_o,
  output logic                        ex_in_delay_slot_o,
  output logic                        ex_valid_o
`ifdef ID_INVALID_TRAP_EN
  ,
  output logic                        ex_exc_ri_o
`endif
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_BGTZ  = 6'h07,
                         OP_ADDIU   = 6'h09, OP_ORI  = 6'h0D, OP_LUI   = 6'h0F,
                         OP_LW      = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] F_JR  = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR  = 6'h25, F_XOR  = 6'h26, F_SLT  = 6'h2A;

  localparam logic [ALUSEL_W-1:0] SEL_NOP   = ALUSEL_W'(0);
  localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(1);
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(2);
  localparam logic [ALUSEL_W-1:0] SEL_JUMP  = ALUSEL_W'(3);
  localparam logic [ALUSEL_W-1:0] SEL_LDST  = ALUSEL_W'(4);

  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [DATA_W-1:0]   reg1;
    logic [DATA_W-1:0]   reg2;
    logic [REG_AW-1:0]   wd;
    logic                wreg;
    logic [31:0]         link_addr;
    logic [31:0]         inst;
    logic                in_delay_slot;
    logic                valid;
`ifdef ID_INVALID_TRAP_EN
    logic                exc_ri;
`endif
  } idex_t;

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] idx26;

  assign opcode = inst_i[31:26];
  assign rs     = inst_i[25:21];
  assign rt     = inst_i[20:16];
  assign rd     = inst_i[15:11];
  assign funct  = inst_i[5:0];
  assign imm16  = inst_i[15:0];
  assign idx26  = inst_i[25:0];

  assign reg1_addr_o = REG_AW'(rs);
  assign reg2_addr_o = REG_AW'(rt);

  logic [31:0]       pc_plus4, pc_plus8, br_target, j_target;
  logic [DATA_W-1:0] imm_sext, imm_zext, imm_lui;

  assign pc_plus4  = pc_i + 32'd4;
  assign pc_plus8  = pc_i + 32'd8;
  assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc_plus4[31:28], idx26, 2'b00};
  assign imm_sext  = {{(DATA_W-16){imm16[15]}}, imm16};
  assign imm_zext  = {{(DATA_W-16){1'b0}}, imm16};
  assign imm_lui   = {imm16, {(DATA_W-16){1'b0}}};

  // Register 0 reads as zero; otherwise the lowest-index matching forward source wins.
  function automatic logic [DATA_W-1:0] resolve_operand(
    input logic [REG_AW-1:0]           addr,
    input logic [DATA_W-1:0]           rf_data,
    input logic [FWD_PORTS-1:0]        wreg,
    input logic [FWD_PORTS*REG_AW-1:0] wd,
    input logic [FWD_PORTS*DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    val = rf_data;
    // Walk oldest to youngest so the youngest match is written last.
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      if (wreg[i] && (wd[i*REG_AW +: REG_AW] == addr)) val = wdata[i*DATA_W +: DATA_W];
    end
    if (addr == '0) val = '0;
    return val;
  endfunction

  logic [DATA_W-1:0] op1, op2;

  // Operand selection with forwarding
  always_comb begin
    op1 = resolve_operand(reg1_addr_o, reg1_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
    op2 = resolve_operand(reg2_addr_o, reg2_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
  end

  logic                known, rd1, rd2, use_imm, wreg_dec, is_branch, taken;
  logic [ALUOP_W-1:0]  aluop_dec;
  logic [ALUSEL_W-1:0] alusel_dec;
  logic [DATA_W-1:0]   imm_ext;
  logic [REG_AW-1:0]   wd_dec;
  logic [31:0]         link_dec, target;

  // Instruction decode and branch resolution
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    known      = 1'b0;
    rd1        = 1'b0;
    rd2        = 1'b0;
    use_imm    = 1'b0;
    imm_ext    = '0;
    wreg_dec   = 1'b0;
    wd_dec     = '0;
    link_dec   = '0;
    is_branch  = 1'b0;
    taken      = 1'b0;
    target     = '0;
    aluop_dec  = '0;
    alusel_dec = SEL_NOP;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_ADDU, F_SUBU, F_SLT, F_AND, F_OR, F_XOR: begin
            known      = 1'b1;
            rd1        = 1'b1;
            rd2        = 1'b1;
            aluop_dec  = ALUOP_W'({2'b00, funct});
            alusel_dec = (funct inside {F_AND, F_OR, F_XOR}) ? SEL_LOGIC : SEL_ARITH;
            wreg_dec   = 1'b1;
            wd_dec     = REG_AW'(rd);
          end
          F_JR: begin
            known      = 1'b1;
            rd1        = 1'b1;
            aluop_dec  = ALUOP_W'({2'b00, funct});
            alusel_dec = SEL_JUMP;
            is_branch  = 1'b1;
            taken      = 1'b1;
            target     = 32'(op1);
          end
          default: ;
        endcase
      end
      OP_ADDIU, OP_ORI, OP_LUI, OP_LW: begin
        known      = 1'b1;
        rd1        = (opcode != OP_LUI);
        use_imm    = 1'b1;
        aluop_dec  = ALUOP_W'({2'b01, opcode});
        wreg_dec   = 1'b1;
        wd_dec     = REG_AW'(rt);
        case (opcode)
          OP_ADDIU: begin alusel_dec = SEL_ARITH; imm_ext = imm_sext; end
          OP_ORI:   begin alusel_dec = SEL_LOGIC; imm_ext = imm_zext; end
          OP_LUI:   begin alusel_dec = SEL_LOGIC; imm_ext = imm_lui;  end
          default:  begin alusel_dec = SEL_LDST;  imm_ext = imm_sext; end
        endcase
      end
      OP_SW: begin
        known      = 1'b1;
        rd1        = 1'b1;
        rd2        = 1'b1;
        aluop_dec  = ALUOP_W'({2'b01, opcode});
        alusel_dec = SEL_LDST;
      end
      OP_BEQ, OP_BNE, OP_BGTZ: begin
        known      = 1'b1;
        rd1        = 1'b1;
        rd2        = (opcode != OP_BGTZ);
        aluop_dec  = ALUOP_W'({2'b01, opcode});
        alusel_dec = SEL_JUMP;
        is_branch  = 1'b1;
        target     = br_target;
        case (opcode)
          OP_BEQ:  taken = (op1 == op2);
          OP_BNE:  taken = (op1 != op2);
          default: taken = !op1[DATA_W-1] && (op1 != '0);
        endcase
      end
      OP_J, OP_JAL: begin
        known      = 1'b1;
        aluop_dec  = ALUOP_W'({2'b01, opcode});
        alusel_dec = SEL_JUMP;
        is_branch  = 1'b1;
        taken      = 1'b1;
        target     = j_target;
        if (opcode == OP_JAL) begin
          wreg_dec = 1'b1;
          wd_dec   = REG_AW'(31);
          link_dec = pc_plus8;
        end
      end
      default: ;
    endcase
  end

  assign reg1_read_o     = inst_valid_i & rd1;
  assign reg2_read_o     = inst_valid_i & rd2;
  assign stallreq_o      = inst_valid_i & ex_is_load_i & (ex_wd_i != '0) &
                           ((reg1_read_o & (ex_wd_i == reg1_addr_o)) |
                            (reg2_read_o & (ex_wd_i == reg2_addr_o)));
  assign branch_flag_o   = inst_valid_i & taken & ~stallreq_o & ~flush_i;
  assign branch_target_o = target;

  idex_t idex_d, idex_q;
  logic  flag_d, flag_q;

  // ID/EX next state: flush > stall hold > bubble > load decoded instruction
  always_comb begin
    idex_d = idex_q;
    flag_d = flag_q;
    if (flush_i) begin
      idex_d = '0;
      flag_d = 1'b0;
    end else if (stall_i) begin
      idex_d = idex_q;
    end else if (stallreq_o || !inst_valid_i) begin
      idex_d = '0;
    end else begin
      idex_d               = '0;
      idex_d.valid         = 1'b1;
      idex_d.inst          = inst_i;
      idex_d.in_delay_slot = flag_q;
      flag_d               = is_branch;
      if (known) begin
        idex_d.aluop     = aluop_dec;
        idex_d.alusel    = alusel_dec;
        idex_d.reg1      = rd1 ? op1 : '0;
        idex_d.reg2      = use_imm ? imm_ext : (rd2 ? op2 : '0);
        idex_d.wd        = wd_dec;
        idex_d.wreg      = wreg_dec;
        idex_d.link_addr = link_dec;
      end
`ifdef ID_INVALID_TRAP_EN
      else begin
        idex_d.exc_ri = 1'b1;
      end
`endif
    end
  end

  // ID/EX register and delay-slot flag
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      idex_q <= '0;
      flag_q <= 1'b0;
    end else begin
      idex_q <= idex_d;
      flag_q <= flag_d;
    end
  end

  assign ex_aluop_o         = idex_q.aluop;
  assign ex_alusel_o        = idex_q.alusel;
  assign ex_reg1_o          = idex_q.reg1;
  assign ex_reg2_o          = idex_q.reg2;
  assign ex_wd_o            = idex_q.wd;
  assign ex_wreg_o          = idex_q.wreg;
  assign ex_link_addr_o     = idex_q.link_addr;
  assign ex_inst_o          = idex_q.inst;
  assign ex_in_delay_slot_o = idex_q.in_delay_slot;
  assign ex_valid_o         = idex_q.valid;
`ifdef ID_INVALID_TRAP_EN
  assign ex_exc_ri_o        = idex_q.exc_ri;
`endif

endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: directed and randomized checks of id_decode_pipe against a
// mnemonic-level reference model. Honours ID_INVALID_TRAP_EN when defined.
module tb_id_decode_pipe;
  localparam int DATA_W = 32, REG_AW = 5, FWD_PORTS = 2, ALUOP_W = 8, ALUSEL_W = 3;

  logic clk = 1'b0;
  logic rst;
  logic stall_i, flush_i, inst_valid_i;
  logic [31:0] pc_i, inst_i;
  logic reg1_read_o, reg2_read_o;
  logic [REG_AW-1:0] reg1_addr_o, reg2_addr_o;
  logic [DATA_W-1:0] reg1_data_i, reg2_data_i;
  logic [FWD_PORTS-1:0] fwd_wreg_i;
  logic [FWD_PORTS*REG_AW-1:0] fwd_wd_i;
  logic [FWD_PORTS*DATA_W-1:0] fwd_wdata_i;
  logic ex_is_load_i;
  logic [REG_AW-1:0] ex_wd_i;
  logic stallreq_o, branch_flag_o;
  logic [31:0] branch_target_o;
  logic [ALUOP_W-1:0] ex_aluop_o;
  logic [ALUSEL_W-1:0] ex_alusel_o;
  logic [DATA_W-1:0] ex_reg1_o, ex_reg2_o;
  logic [REG_AW-1:0] ex_wd_o;
  logic ex_wreg_o, ex_in_delay_slot_o, ex_valid_o;
  logic [31:0] ex_link_addr_o, ex_inst_o;
`ifdef ID_INVALID_TRAP_EN
  logic ex_exc_ri_o;
`endif

  always #5 clk = ~clk;

  logic [DATA_W-1:0] rf [32];
  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  id_decode_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS),
                   .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .pc_i(pc_i),
    .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
    .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_is_load_i(ex_is_load_i), .ex_wd_i(ex_wd_i),
    .stallreq_o(stallreq_o), .branch_flag_o(branch_flag_o), .branch_target_o(branch_target_o),
    .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o),
    .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
    .ex_link_addr_o(ex_link_addr_o), .ex_inst_o(ex_inst_o),
    .ex_in_delay_slot_o(ex_in_delay_slot_o), .ex_valid_o(ex_valid_o)
`ifdef ID_INVALID_TRAP_EN
    , .ex_exc_ri_o(ex_exc_ri_o)
`endif
  );

  typedef enum int {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_JR, M_ADDIU, M_ORI, M_LUI,
                    M_LW, M_SW, M_BEQ, M_BNE, M_BGTZ, M_J, M_JAL, M_BAD, M_BADF} mn_t;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] link, inst;
    logic        in_ds, valid, exc_ri;
  } ex_t;

  ex_t  exp_ex;
  logic exp_flag;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encode(input mn_t m, input logic [4:0] rs, rt, rd,
                                         input logic [15:0] imm, input logic [25:0] idx);
    case (m)
      M_ADDU:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      M_SUBU:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      M_AND:   return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      M_OR:    return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      M_XOR:   return {6'h00, rs, rt, rd, 5'd0, 6'h26};
      M_SLT:   return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      M_JR:    return {6'h00, rs, 15'd0, 6'h08};
      M_ADDIU: return {6'h09, rs, rt, imm};
      M_ORI:   return {6'h0D, rs, rt, imm};
      M_LUI:   return {6'h0F, 5'd0, rt, imm};
      M_LW:    return {6'h23, rs, rt, imm};
      M_SW:    return {6'h2B, rs, rt, imm};
      M_BEQ:   return {6'h04, rs, rt, imm};
      M_BNE:   return {6'h05, rs, rt, imm};
      M_BGTZ:  return {6'h07, rs, 5'd0, imm};
      M_J:     return {6'h02, idx};
      M_JAL:   return {6'h03, idx};
      M_BAD:   return {6'h3F, idx};
      default: return {6'h00, rs, rt, rd, 5'd0, 6'h3F};
    endcase
  endfunction

  function automatic logic [7:0] aluop_of(input mn_t m);
    case (m)
      M_ADDU: return 8'h21;  M_SUBU: return 8'h23;  M_AND:   return 8'h24;
      M_OR:   return 8'h25;  M_XOR:  return 8'h26;  M_SLT:   return 8'h2A;
      M_JR:   return 8'h08;  M_ADDIU: return 8'h49; M_ORI:   return 8'h4D;
      M_LUI:  return 8'h4F;  M_LW:   return 8'h63;  M_SW:    return 8'h6B;
      M_BEQ:  return 8'h44;  M_BNE:  return 8'h45;  M_BGTZ:  return 8'h47;
      M_J:    return 8'h42;  M_JAL:  return 8'h43;  default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] alusel_of(input mn_t m);
    if (m inside {M_ADDU, M_SUBU, M_SLT, M_ADDIU}) return 3'd1;
    if (m inside {M_AND, M_OR, M_XOR, M_ORI, M_LUI}) return 3'd2;
    if (m inside {M_JR, M_BEQ, M_BNE, M_BGTZ, M_J, M_JAL}) return 3'd3;
    if (m inside {M_LW, M_SW}) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit reads_rs(input mn_t m);
    return m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_JR, M_ADDIU, M_ORI,
                     M_LW, M_SW, M_BEQ, M_BNE, M_BGTZ};
  endfunction

  function automatic bit reads_rt(input mn_t m);
    return m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_SW, M_BEQ, M_BNE};
  endfunction

  function automatic logic [31:0] opval(input logic [4:0] addr);
    if (addr == 0) return 32'd0;
    for (int i = 0; i < FWD_PORTS; i++)
      if (fwd_wreg_i[i] && fwd_wd_i[i*REG_AW +: REG_AW] == addr) return fwd_wdata_i[i*DATA_W +: DATA_W];
    return rf[addr];
  endfunction

  task automatic check_ex(input string tag);
    check({tag, ".aluop"}, ex_aluop_o, exp_ex.aluop);
    check({tag, ".alusel"}, ex_alusel_o, exp_ex.alusel);
    check({tag, ".reg1"}, ex_reg1_o, exp_ex.reg1);
    check({tag, ".reg2"}, ex_reg2_o, exp_ex.reg2);
    check({tag, ".wd"}, ex_wd_o, exp_ex.wd);
    check({tag, ".wreg"}, ex_wreg_o, exp_ex.wreg);
    check({tag, ".link"}, ex_link_addr_o, exp_ex.link);
    check({tag, ".inst"}, ex_inst_o, exp_ex.inst);
    check({tag, ".in_ds"}, ex_in_delay_slot_o, exp_ex.in_ds);
    check({tag, ".valid"}, ex_valid_o, exp_ex.valid);
`ifdef ID_INVALID_TRAP_EN
    check({tag, ".exc_ri"}, ex_exc_ri_o, exp_ex.exc_ri);
`endif
  endtask

  // Drive one ID cycle, check combinational outputs, advance the model, check ID/EX.
  task automatic run_step(input string tag, input mn_t m, input logic [4:0] rs, rt, rd,
                          input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] pc,
                          input logic valid, stall, flush);
    logic [31:0] ins, a, b, tgt, sx;
    logic taken, stl, bfl;
    ex_t nxt;
    ins = encode(m, rs, rt, rd, imm, idx);
    inst_i = ins; pc_i = pc; inst_valid_i = valid; stall_i = stall; flush_i = flush;
    a  = opval(rs);
    b  = opval(rt);
    sx = 32'($signed(imm));
    stl = valid && ex_is_load_i && ex_wd_i != 0 &&
          ((reads_rs(m) && rs == ex_wd_i) || (reads_rt(m) && rt == ex_wd_i));
    case (m)
      M_JR:   begin taken = 1; tgt = a; end
      M_J, M_JAL: begin taken = 1; tgt = ((pc + 32'd4) & 32'hF000_0000) | (32'(idx) * 4); end
      M_BEQ:  begin taken = (a == b); tgt = pc + 32'd4 + sx * 4; end
      M_BNE:  begin taken = (a != b); tgt = pc + 32'd4 + sx * 4; end
      M_BGTZ: begin taken = ($signed(a) > 0); tgt = pc + 32'd4 + sx * 4; end
      default: begin taken = 0; tgt = 32'd0; end
    endcase
    bfl = valid && taken && !stl && !flush;
    #1;
    check({tag, ".stallreq"}, stallreq_o, stl);
    check({tag, ".rd1"}, reg1_read_o, valid && reads_rs(m));
    check({tag, ".rd2"}, reg2_read_o, valid && reads_rt(m));
    check({tag, ".bflag"}, branch_flag_o, bfl);
    if (bfl) check({tag, ".target"}, branch_target_o, tgt);
    if (flush) begin
      exp_ex = '0; exp_flag = 0;
    end else if (stall) begin
      exp_ex = exp_ex;
    end else if (stl || !valid) begin
      exp_ex = '0;
    end else begin
      nxt = '0; nxt.valid = 1; nxt.inst = ins; nxt.in_ds = exp_flag;
      if (m inside {M_BAD, M_BADF}) begin
        nxt.exc_ri = 1;
      end else begin
        nxt.aluop  = aluop_of(m);
        nxt.alusel = alusel_of(m);
        nxt.reg1   = reads_rs(m) ? a : 32'd0;
        case (m)
          M_ADDIU, M_LW: nxt.reg2 = sx;
          M_ORI:         nxt.reg2 = {16'h0, imm};
          M_LUI:         nxt.reg2 = {imm, 16'h0};
          default:       nxt.reg2 = reads_rt(m) ? b : 32'd0;
        endcase
        if (m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT}) begin
          nxt.wd = rd; nxt.wreg = 1;
        end else if (m inside {M_ADDIU, M_ORI, M_LUI, M_LW}) begin
          nxt.wd = rt; nxt.wreg = 1;
        end else if (m == M_JAL) begin
          nxt.wd = 5'd31; nxt.wreg = 1; nxt.link = pc + 32'd8;
        end
      end
      exp_flag = m inside {M_JR, M_BEQ, M_BNE, M_BGTZ, M_J, M_JAL};
      exp_ex   = nxt;
    end
    @(posedge clk); #1;
    check_ex(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mn_t m;
    rst = 1; stall_i = 0; flush_i = 0; pc_i = 0; inst_i = 0; inst_valid_i = 0;
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; ex_is_load_i = 0; ex_wd_i = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    exp_ex = '0; exp_flag = 0;
    #12;
    check_ex("reset");
    rst = 0;
    @(posedge clk); #1;

    // ADDU r3,r1,r2 from the regfile
    rf[1] = 32'd5; rf[2] = 32'd7;
    run_step("t1", M_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1, 0, 0);
    check("t1.aluop_const", ex_aluop_o, 8'h21);
    check("t1.reg1_const", ex_reg1_o, 32'd5);
    check("t1.reg2_const", ex_reg2_o, 32'd7);
    check("t1.wd_const", ex_wd_o, 5'd3);

    // Youngest forward source wins; destination 0 never forwards
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'd4, 32'd9};
    run_step("t2", M_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h4, 1, 0, 0);
    check("t2.reg1_const", ex_reg1_o, 32'd9);
    fwd_wd_i = {5'd0, 5'd0}; fwd_wdata_i = {32'hAAAA_0000, 32'hBBBB_0000};
    run_step("t2z", M_ADDU, 5'd0, 5'd2, 5'd3, 16'h0, 26'h0, 32'h8, 1, 0, 0);
    check("t2z.reg1_const", ex_reg1_o, 32'd0);
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;

    // Load-use hazard on a branch
    ex_is_load_i = 1; ex_wd_i = 5'd2;
    run_step("t3", M_BEQ, 5'd1, 5'd2, 5'd0, 16'h4, 26'h0, 32'h200, 1, 0, 0);
    check("t3.stallreq_const", stallreq_o, 1'b1);
    check("t3.bflag_const", branch_flag_o, 1'b0);
    check("t3.bubble_const", ex_valid_o, 1'b0);
    ex_is_load_i = 0; ex_wd_i = '0;

    // Taken backward branch and its delay slot
    run_step("t4", M_BEQ, 5'd1, 5'd1, 5'd0, 16'hFFFF, 26'h0, 32'h100, 1, 0, 0);
    check("t4.bflag_const", branch_flag_o, 1'b1);
    check("t4.target_const", branch_target_o, 32'h100);
    run_step("t4ds", M_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h104, 1, 0, 0);
    check("t4ds.in_ds_const", ex_in_delay_slot_o, 1'b1);

    // JAL, then a flush that clears the delay-slot flag
    run_step("t5", M_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 32'h1000, 1, 0, 0);
    check("t5.target_const", branch_target_o, 32'h100);
    check("t5.wd_const", ex_wd_o, 5'd31);
    check("t5.link_const", ex_link_addr_o, 32'h1008);
    run_step("t5f", M_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h1004, 1, 0, 1);
    check("t5f.valid_const", ex_valid_o, 1'b0);
    run_step("t5n", M_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h1008, 1, 0, 0);
    check("t5n.in_ds_const", ex_in_delay_slot_o, 1'b0);

    // Asynchronous reset mid-stream clears ID/EX and the delay-slot flag
    run_step("t6a", M_BNE, 5'd1, 5'd2, 5'd0, 16'h8, 26'h0, 32'h2000, 1, 0, 0);
    #2 rst = 1;
    #1;
    check("t6.rst_valid", ex_valid_o, 1'b0);
    check("t6.rst_aluop", ex_aluop_o, 8'h00);
    check("t6.rst_inst", ex_inst_o, 32'h0);
    exp_ex = '0; exp_flag = 0;
    check_ex("t6.rst");
    #1 rst = 0;
    run_step("t6b", M_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h2008, 1, 0, 0);
    check("t6b.in_ds_const", ex_in_delay_slot_o, 1'b0);

    // Unknown opcode: valid bubble, no write
    run_step("t7", M_BAD, 5'd0, 5'd0, 5'd0, 16'h0, 26'h12345, 32'h3000, 1, 0, 0);
    check("t7.valid_const", ex_valid_o, 1'b1);
    check("t7.wreg_const", ex_wreg_o, 1'b0);
`ifdef ID_INVALID_TRAP_EN
    check("t7.exc_ri_const", ex_exc_ri_o, 1'b1);
`endif

    // Randomized traffic against the reference model
    for (int it = 0; it < 400; it++) begin
      if (it % 50 == 0) for (int r = 1; r < 32; r++) rf[r] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      for (int p = 0; p < FWD_PORTS; p++) begin
        fwd_wreg_i[p] = $urandom_range(0, 1);
        fwd_wd_i[p*REG_AW +: REG_AW] = 5'($urandom_range(0, 7));
        fwd_wdata_i[p*DATA_W +: DATA_W] = $urandom;
      end
      ex_is_load_i = ($urandom_range(0, 2) == 0);
      ex_wd_i = 5'($urandom_range(0, 7));
      m = mn_t'($urandom_range(0, 18));
      run_step("rand", m, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 16'($urandom), 26'($urandom), $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
